// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch sequencer state type and address constants
package cpu_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC1  = 3'd2,
    EXEC2  = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDRESS = 32'h0000_0000;
endpackage

// File: rtl/instr_reg.sv
// instr_reg: 32-bit instruction register with load enable.
// Optional INSTR_BYTESWAP_EN byte-reverses the word before latching.
module instr_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);
  logic [31:0] word;
`ifdef INSTR_BYTESWAP_EN
  assign word = {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
  assign word = d;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (load) q <= word;
endmodule

// File: rtl/instr_fetch_fsm.sv
// instr_fetch_fsm: fetch/exec phase sequencer and instruction latch with halt detect.
// INSTR_BYTESWAP_EN (optional) byte-reverses fetched words in instr_reg.
module instr_fetch_fsm
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDRESS = cpu_pkg::HALT_ADDRESS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        mem_stall,
  output logic [31:0] address,
  output logic        read,
  output logic        fetch,
  output logic        exec_one,
  output logic        exec_two,
  output logic [31:0] current_instruction,
  output logic        pc_en,
  output logic        active
);
  fetch_state_t state;
  logic halt_pc, load, unused_rv;
  // the PC block owns the reset vector; kept only as a documented parameter
  assign unused_rv = ^RESET_VECTOR;
  assign halt_pc   = pc == HALT_ADDRESS;
  assign fetch     = state == FETCH;
  assign exec_one  = state == EXEC1;
  assign exec_two  = state == EXEC2;
  assign read      = fetch && !halt_pc;
  assign address   = fetch ? pc : '0;
  assign load      = read && !waitrequest;
  assign pc_en     = exec_two && !mem_stall;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      active <= 1'b0;
    end else
      case (state)
        IDLE: begin
          state  <= FETCH;
          active <= 1'b1;
        end
        FETCH:
          if (halt_pc) begin
            state  <= HALTED;
            active <= 1'b0;
          end else if (!waitrequest) state <= EXEC1;
        EXEC1:   state <= EXEC2;
        EXEC2:   if (!mem_stall) state <= FETCH;
        default: state <= HALTED;
      endcase
  instr_reg u_ir (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (readdata),
    .q     (current_instruction)
  );
endmodule
